// File: rtl/itercnt_if.sv
// Request/response bundle for the iterative bit-count unit.
// The master drives requests and consumes results; the slave is the unit itself.
interface itercnt_if #(
   parameter int WIDTH = 64
);
   logic             Flush;
   logic             InValid;
   logic             InReady;
   logic [WIDTH-1:0] A;
   logic [1:0]       Op;
   logic             W64;
   logic             OutValid;
   logic             OutReady;
   logic [WIDTH-1:0] Result;

   modport master (
      output Flush, InValid, A, Op, W64, OutReady,
      input  InReady, OutValid, Result
   );

   modport slave (
      input  Flush, InValid, A, Op, W64, OutReady,
      output InReady, OutValid, Result
   );
endinterface

// File: rtl/itercnt.sv
// Iterative clz/ctz/cpop: scans CHUNK bits per cycle, exits early on the first
// non-zero chunk for clz/ctz, and holds the count until the consumer takes it.
module itercnt #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 8
) (
   input  logic      clk,
   input  logic      reset_n,
   itercnt_if.slave  bus
);
   localparam int NCH = WIDTH / CHUNK;
   localparam int NW  = 32 / CHUNK;
   localparam int IW  = $clog2(NCH);
   localparam int AW  = $clog2(WIDTH) + 1;
   localparam int CW  = $clog2(CHUNK) + 1;

   localparam logic [1:0] OP_CLZ  = 2'b00;
   localparam logic [1:0] OP_CTZ  = 2'b01;
   localparam logic [1:0] OP_CPOP = 2'b10;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [AW-1:0]    r_result;
   logic [AW-1:0]    r_acc;
   logic [IW-1:0]    r_idx;
   logic [IW-1:0]    r_last_idx;
   logic [WIDTH-1:0] r_opnd;
   logic [1:0]       r_op;

   logic             w_word;
   logic [WIDTH-1:0] w_opnd_in;
   logic [CHUNK-1:0] w_chunks [NCH];
   logic [IW-1:0]    w_chunk_sel;
   logic [CHUNK-1:0] w_chunk;
   logic [CW-1:0]    w_lz;
   logic [CW-1:0]    w_tz;
   logic [CW-1:0]    w_pc;
   logic [CW-1:0]    w_add;
   logic [AW-1:0]    w_acc_next;
   logic             w_finish;

   // Word mode only exists on a 64-bit unit; the word sits in the low 32 bits.
   assign w_word = (WIDTH == 64) && bus.W64;

   always_comb begin
      w_opnd_in = bus.A;
      if (w_word) begin
         w_opnd_in        = '0;
         w_opnd_in[31:0]  = bus.A[31:0];
      end
   end

   for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
      assign w_chunks[gi] = r_opnd[gi*CHUNK +: CHUNK];
   end

   // clz walks the chunk index downward from the top of the scan length.
   assign w_chunk_sel = (r_op == OP_CLZ) ? (r_last_idx - r_idx) : r_idx;
   assign w_chunk     = w_chunks[w_chunk_sel];

   always_comb begin
      logic found_l;
      logic found_t;
      w_lz    = '0;
      w_tz    = '0;
      w_pc    = '0;
      found_l = 1'b0;
      found_t = 1'b0;
      for (int i = CHUNK - 1; i >= 0; i--) begin
         if (w_chunk[i]) found_l = 1'b1;
         else if (!found_l) w_lz = w_lz + CW'(1);
      end
      for (int i = 0; i < CHUNK; i++) begin
         if (w_chunk[i]) begin
            found_t = 1'b1;
            w_pc    = w_pc + CW'(1);
         end else if (!found_t) begin
            w_tz = w_tz + CW'(1);
         end
      end
   end

   always_comb begin
      case (r_op)
         OP_CLZ:  w_add = w_lz;
         OP_CTZ:  w_add = w_tz;
         OP_CPOP: w_add = w_pc;
         default: w_add = '0;
      endcase
   end

   assign w_acc_next = r_acc + AW'(w_add);

   // An all-zero chunk contributes CHUNK zeros and keeps the scan going.
   assign w_finish = (r_op == 2'b11) || (r_idx == r_last_idx) ||
                     ((r_op != OP_CPOP) && (w_chunk != '0));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_acc       <= '0;
         r_idx       <= '0;
         r_last_idx  <= '0;
         r_opnd      <= '0;
         r_op        <= '0;
      end else if (bus.Flush) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_acc       <= '0;
         r_idx       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.InValid) begin
                  r_opnd     <= w_opnd_in;
                  r_op       <= bus.Op;
                  r_acc      <= '0;
                  r_idx      <= '0;
                  r_last_idx <= w_word ? IW'(NW - 1) : IW'(NCH - 1);
                  r_in_ready <= 1'b0;
                  r_state    <= BUSY;
               end
            end
            BUSY: begin
               r_acc <= w_acc_next;
               r_idx <= r_idx + IW'(1);
               if (w_finish) begin
                  r_result    <= (r_op == 2'b11) ? '0 : w_acc_next;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (bus.OutReady) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.InReady  = r_in_ready;
   assign bus.OutValid = r_out_valid;
   assign bus.Result   = {{(WIDTH - AW){1'b0}}, r_result};
endmodule

// File: tb/tb_itercnt.sv
// Scoreboarded bench: the driver queues expected count and completion cycle,
// a negedge monitor compares them when OutValid rises.
module tb_itercnt;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   itercnt_if #(.WIDTH(64)) b1 ();
   itercnt_if #(.WIDTH(32)) b2 ();

   itercnt #(.WIDTH(64), .CHUNK(8)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));
   itercnt #(.WIDTH(32), .CHUNK(4)) dut2 (.clk(clk), .reset_n(reset_n), .bus(b2));

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] res;
      int          done_cyc;
      string       name;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      string       name;
      logic [63:0] a;
      logic [1:0]  op;
      logic        w64;
      logic [63:0] res;
      int          lat;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   logic prev_ov = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (b1.OutValid && !prev_ov) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %0d expected no output", b1.Result);
         end else begin
            e = sb.pop_front();
            check({e.name, "_result"}, b1.Result, e.res);
            check({e.name, "_latency"}, 64'(cyc), 64'(e.done_cyc));
            $display("txn %s: result=%0d (exp %0d) cycle=%0d (exp %0d)",
                     e.name, b1.Result, e.res, cyc, e.done_cyc);
         end
      end
      prev_ov = b1.OutValid;
   end

   task automatic issue(input string name, input logic [63:0] a, input logic [1:0] op,
                        input logic w64, input logic [63:0] res, input int lat, input bit push);
      int t = 0;
      @(negedge clk);
      while (!b1.InReady && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!b1.InReady) begin
         checks++;
         errors++;
         $display("FAIL %s_accept_timeout: InReady=0 required 1", name);
      end
      b1.A = a;
      b1.Op = op;
      b1.W64 = w64;
      b1.InValid = 1'b1;
      @(posedge clk);
      #1;
      b1.InValid = 1'b0;
      b1.A = ~a;
      b1.Op = op ^ 2'b01;
      b1.W64 = ~w64;
      if (push) sb.push_back('{res, cyc + lat, name});
   endtask

   task automatic wait_valid(input string name);
      int t = 0;
      @(negedge clk);
      while (!b1.OutValid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!b1.OutValid) begin
         checks++;
         errors++;
         $display("FAIL %s_valid_timeout: OutValid=0 required 1", name);
      end
   endtask

   task automatic wait_done(input string name);
      wait_valid(name);
      b1.OutReady = 1'b1;
      @(posedge clk);
      #1;
      b1.OutReady = 1'b0;
      check({name, "_idle_inready"}, 64'(b1.InReady), 64'd1);
      check({name, "_idle_outvalid"}, 64'(b1.OutValid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1);
   end

   initial begin
      int k;
      int t;
      b1.Flush = 0; b1.InValid = 0; b1.A = '0; b1.Op = '0; b1.W64 = 0; b1.OutReady = 0;
      b2.Flush = 0; b2.InValid = 0; b2.A = '0; b2.Op = '0; b2.W64 = 0; b2.OutReady = 0;

      #12;
      check("reset_outvalid", 64'(b1.OutValid), 64'd0);
      check("reset_result", b1.Result, 64'd0);
      check("reset_inready", 64'(b1.InReady), 64'd1);
      check("reset_inready_w32", 64'(b2.InReady), 64'd1);
      @(negedge clk);
      reset_n = 1'b1;

      vecs.push_back('{"cpop_ones",      64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 64'd64, 8});
      vecs.push_back('{"clz_bit23",      64'h0000_0000_0080_0000, 2'b00, 1'b0, 64'd40, 6});
      vecs.push_back('{"ctz_word_zero",  64'hDEAD_BEEF_0000_0000, 2'b01, 1'b1, 64'd32, 4});
      vecs.push_back('{"ctz_bit8",       64'h0000_0000_0000_0100, 2'b01, 1'b0, 64'd8,  2});
      vecs.push_back('{"clz_msb",        64'h8000_0000_0000_0000, 2'b00, 1'b0, 64'd0,  1});
      vecs.push_back('{"clz_zero",       64'h0000_0000_0000_0000, 2'b00, 1'b0, 64'd64, 8});
      vecs.push_back('{"op_reserved",    64'hFFFF_0000_FFFF_0000, 2'b11, 1'b0, 64'd0,  1});
      vecs.push_back('{"cpop_word",      64'hFFFF_FFFF_0000_000F, 2'b10, 1'b1, 64'd4,  4});
      vecs.push_back('{"clz_word_bit16", 64'h1234_5678_0001_0000, 2'b00, 1'b1, 64'd15, 2});
      vecs.push_back('{"ctz_msb",        64'h8000_0000_0000_0000, 2'b01, 1'b0, 64'd63, 8});
      vecs.push_back('{"cpop_mixed",     64'h0123_4567_89AB_CDEF, 2'b10, 1'b0, 64'd32, 8});

      foreach (vecs[i]) begin
         issue(vecs[i].name, vecs[i].a, vecs[i].op, vecs[i].w64, vecs[i].res, vecs[i].lat, 1'b1);
         wait_done(vecs[i].name);
      end

      // Backpressure with a pending request held on the input side.
      issue("bp_cpop", 64'h0000_0000_0000_00F0, 2'b10, 1'b0, 64'd4, 8, 1'b1);
      wait_valid("bp_cpop");
      b1.A = 64'h0000_0001_0000_0000;
      b1.Op = 2'b00;
      b1.W64 = 1'b0;
      b1.InValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_result_stable", b1.Result, 64'd4);
         check("bp_inready_low", 64'(b1.InReady), 64'd0);
         check("bp_outvalid_high", 64'(b1.OutValid), 64'd1);
      end
      b1.OutReady = 1'b1;
      @(posedge clk);
      #1;
      b1.OutReady = 1'b0;
      check("bp_release_inready", 64'(b1.InReady), 64'd1);
      @(posedge clk);
      #1;
      b1.InValid = 1'b0;
      sb.push_back('{64'd31, cyc + 4, "bp_next"});
      check("bp_next_accepted", 64'(b1.InReady), 64'd0);
      wait_done("bp_next");

      // Flush during a cpop scan.
      issue("flush_cpop", 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 64'd0, 0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      b1.Flush = 1'b1;
      @(posedge clk);
      #1;
      b1.Flush = 1'b0;
      check("flush_outvalid", 64'(b1.OutValid), 64'd0);
      check("flush_inready", 64'(b1.InReady), 64'd1);
      issue("flush_then_clz", 64'h1, 2'b00, 1'b0, 64'd63, 8, 1'b1);
      wait_done("flush_then_clz");

      // Flush and OutReady together in DONE.
      issue("flush_done_ctz", 64'h1, 2'b01, 1'b0, 64'd0, 1, 1'b1);
      wait_valid("flush_done_ctz");
      b1.Flush = 1'b1;
      b1.OutReady = 1'b1;
      @(posedge clk);
      #1;
      b1.Flush = 1'b0;
      b1.OutReady = 1'b0;
      check("flush_done_inready", 64'(b1.InReady), 64'd1);
      check("flush_done_outvalid", 64'(b1.OutValid), 64'd0);

      // Asynchronous reset in the middle of BUSY on both units.
      b2.A = '0;
      b2.Op = 2'b00;
      b2.InValid = 1'b1;
      issue("rst_cpop", 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 64'd0, 0, 1'b0);
      b2.InValid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_rst_outvalid", 64'(b1.OutValid), 64'd0);
      check("async_rst_result", b1.Result, 64'd0);
      check("async_rst_inready", 64'(b1.InReady), 64'd1);
      check("async_rst_inready_w32", 64'(b2.InReady), 64'd1);
      check("async_rst_outvalid_w32", 64'(b2.OutValid), 64'd0);
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;

      // 32-bit unit, 4-bit chunks: clz of zero scans all 8 chunks.
      @(negedge clk);
      b2.A = '0;
      b2.Op = 2'b00;
      b2.InValid = 1'b1;
      @(posedge clk);
      #1;
      k = cyc;
      b2.InValid = 1'b0;
      b2.A = 32'hFFFF_FFFF;
      t = 0;
      @(negedge clk);
      while (!b2.OutValid && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("w32_clz_zero_result", 64'(b2.Result), 64'd32);
      check("w32_clz_zero_latency", 64'(cyc), 64'(k + 8));
      $display("txn w32_clz_zero: result=%0d (exp 32) cycle=%0d (exp %0d)", b2.Result, cyc, k + 8);
      b2.OutReady = 1'b1;
      @(posedge clk);
      #1;
      b2.OutReady = 1'b0;
      check("w32_idle_inready", 64'(b2.InReady), 64'd1);

      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
